// File: rtl/sar_conv_sequencer.sv
// Host-side sequencer for a 3-bit SAR ADC controller: launches conversions,
// captures the final code into a small FIFO, and tracks count/timeout/overflow.
module sar_conv_sequencer #(
    parameter int CODE_W   = 3,
    parameter int DEPTH    = 4,
    parameter int MIN_WAIT = 1,
    parameter int TIMEOUT  = 16,
    parameter int CNT_W    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           continuous,
    input  logic                           sar_done,
    input  logic [CODE_W-1:0]              sar_sel,
    output logic                           sar_reset,
    output logic                           busy,
    output logic [CODE_W-1:0]              dout,
    output logic                           dout_valid,
    input  logic                           dout_ready,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_level,
    output logic [CNT_W-1:0]               conv_count,
    output logic                           overflow,
    output logic                           timeout_err,
    input  logic                           clear_flags
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int WCNT_W = $clog2(TIMEOUT);

    localparam logic [WCNT_W-1:0] L_MIN_WAIT = WCNT_W'(MIN_WAIT);
    localparam logic [WCNT_W-1:0] L_TMO_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [LVL_W-1:0]  L_DEPTH    = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    state_t              r_state;
    logic [WCNT_W-1:0]   r_wait_cnt;
    logic                r_sar_reset;
    logic                r_busy;
    logic [CNT_W-1:0]    r_conv_count;
    logic                r_overflow;
    logic                r_timeout_err;

    logic [CODE_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]    r_level;

    logic w_capture;
    logic w_timeout;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_overflow;

    // A done seen during the first MIN_WAIT cycles is left over from the
    // previous conversion, so it is never treated as a capture.
    assign w_capture  = (r_state == S_WAIT) && (r_wait_cnt >= L_MIN_WAIT) && sar_done;
    assign w_timeout  = (r_state == S_WAIT) && !w_capture && (r_wait_cnt == L_TMO_LAST);
    assign w_full     = (r_level == L_DEPTH);
    assign w_pop      = (r_level != '0) && dout_ready;
    assign w_push     = w_capture && (!w_full || w_pop);
    assign w_overflow = w_capture && w_full && !w_pop;

    // NOTE: state registers use non-blocking assignments so every block sees
    // pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_sar_reset <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start || continuous) begin
                        r_state     <= S_START;
                        r_sar_reset <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_START: begin
                    r_state     <= S_WAIT;
                    r_sar_reset <= 1'b0;
                    r_wait_cnt  <= '0;
                end
                S_WAIT: begin
                    if (w_capture) begin
                        if (continuous) begin
                            r_state     <= S_START;
                            r_sar_reset <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_sar_reset <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Flags are sticky; a set event in the same cycle as clear_flags wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_conv_count  <= '0;
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_capture) begin
                r_conv_count <= r_conv_count + CNT_W'(1);
            end
            if (w_overflow) begin
                r_overflow <= 1'b1;
            end else if (clear_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (clear_flags) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    // NOTE: the storage array is reset as well because dout reads the head
    // entry directly and must be 0 out of reset; this is cheap at this depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= sar_sel;
                r_wr_ptr        <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign sar_reset   = r_sar_reset;
    assign busy        = r_busy;
    assign dout        = r_mem[r_rd_ptr];
    assign dout_valid  = (r_level != '0);
    assign fifo_level  = r_level;
    assign conv_count  = r_conv_count;
    assign overflow    = r_overflow;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Directed bench for sar_conv_sequencer with a behavioural SAR controller that
// keeps a stale done through START so the done mask is exercised.
module tb_sar_conv_sequencer;

    localparam int CODE_W   = 3;
    localparam int DEPTH    = 4;
    localparam int MIN_WAIT = 1;
    localparam int TIMEOUT  = 16;
    localparam int CNT_W    = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              continuous;
    logic              sar_done;
    logic [CODE_W-1:0] sar_sel;
    logic              sar_reset;
    logic              busy;
    logic [CODE_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic [2:0]        fifo_level;
    logic [CNT_W-1:0]  conv_count;
    logic              overflow;
    logic              timeout_err;
    logic              clear_flags;

    int n_checks = 0;
    int n_fail   = 0;

    sar_conv_sequencer #(
        .CODE_W  (CODE_W),
        .DEPTH   (DEPTH),
        .MIN_WAIT(MIN_WAIT),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .continuous (continuous),
        .sar_done   (sar_done),
        .sar_sel    (sar_sel),
        .sar_reset  (sar_reset),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fifo_level (fifo_level),
        .conv_count (conv_count),
        .overflow   (overflow),
        .timeout_err(timeout_err),
        .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    // SAR controller model: sel=011 on its reset edge (done left stale),
    // final code plus done one edge later unless m_hang holds done low.
    logic [CODE_W-1:0] m_codes [64];
    int                m_idx  = 0;
    logic              m_hang = 1'b0;
    logic              m_phase;
    int                next_idx = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sar_done <= 1'b0;
            sar_sel  <= '0;
            m_phase  <= 1'b0;
        end else if (sar_reset) begin
            sar_sel <= 3'b011;
            m_phase <= 1'b1;
        end else if (m_phase) begin
            m_phase <= 1'b0;
            if (m_hang) begin
                sar_done <= 1'b0;
            end else begin
                sar_done <= 1'b1;
                sar_sel  <= m_codes[m_idx[5:0]];
                m_idx    <= m_idx + 1;
            end
        end
    end

    typedef struct {
        logic [2:0] code;
        logic [2:0] exp_head;
        logic [2:0] exp_level;
        int         exp_count;
    } conv_vec_t;

    conv_vec_t   fill_vec [4];
    logic [2:0]  drained [$];
    logic [2:0]  got [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        start       = 1'b0;
        continuous  = 1'b0;
        dout_ready  = 1'b0;
        clear_flags = 1'b0;
        reset       = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_single(input logic [2:0] code, output int busy_cyc);
        m_codes[next_idx] = code;
        next_idx++;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cyc++;
        end
    endtask

    task automatic drain_fifo();
        drained.delete();
        @(posedge clk);
        #1 dout_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            @(negedge clk);
            if (!dout_valid) break;
            drained.push_back(dout);
        end
        dout_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          bc;
        int          pulses;
        int          last_pulse;
        int          gap_bad;
        logic        ov_before;
        logic        tmo_early;
        logic [2:0]  exp_seq [4];

        fill_vec[0] = '{3'b100, 3'b100, 3'd1, 1};
        fill_vec[1] = '{3'b101, 3'b100, 3'd2, 2};
        fill_vec[2] = '{3'b110, 3'b100, 3'd3, 3};
        fill_vec[3] = '{3'b111, 3'b100, 3'd4, 4};

        // Reset state and a single-shot conversion with start held one extra cycle
        do_reset();
        @(negedge clk);
        check("rst_sar_reset", sar_reset, 0);
        check("rst_busy", busy, 0);
        check("rst_dout", dout, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_count", conv_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_timeout", timeout_err, 0);

        m_codes[next_idx] = 3'b110;
        next_idx++;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("s1_start_sar_reset", sar_reset, 1);
        check("s1_start_busy", busy, 1);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("s1_wait0_sar_reset", sar_reset, 0);
        check("s1_wait0_busy", busy, 1);
        check("s1_wait0_valid", dout_valid, 0);
        @(negedge clk);
        check("s1_wait1_busy", busy, 1);
        check("s1_wait1_valid", dout_valid, 0);
        @(negedge clk);
        check("s1_done_busy", busy, 0);
        check("s1_done_valid", dout_valid, 1);
        check("s1_done_dout", dout, 3'b110);
        check("s1_done_count", conv_count, 1);
        check("s1_done_level", fifo_level, 1);
        @(negedge clk);
        check("s1_no_restart", busy, 0);
        dout_ready = 1'b1;
        @(posedge clk);
        #1 dout_ready = 1'b0;
        @(negedge clk);
        check("s1_pop_valid", dout_valid, 0);
        check("s1_pop_level", fifo_level, 0);

        // Free-running with the consumer always ready
        do_reset();
        exp_seq[0] = 3'b000;
        exp_seq[1] = 3'b010;
        exp_seq[2] = 3'b111;
        exp_seq[3] = 3'b100;
        for (int k = 0; k < 4; k++) begin
            m_codes[next_idx + k] = exp_seq[k];
        end
        next_idx += 4;
        got.delete();
        pulses = 0;
        last_pulse = -1;
        gap_bad = 0;
        #1;
        continuous = 1'b1;
        dout_ready = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            if (sar_reset) begin
                if (pulses > 0 && cyc - last_pulse != 3) gap_bad++;
                last_pulse = cyc;
                pulses++;
            end
            if (dout_valid && dout_ready) got.push_back(dout);
            if (pulses == 4 && !sar_reset && continuous) continuous = 1'b0;
            if (got.size() == 4 && !busy) break;
        end
        dout_ready = 1'b0;
        check("cont_pulses", pulses, 4);
        check("cont_gap", gap_bad, 0);
        check("cont_got_n", got.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) check($sformatf("cont_dout_%0d", k), got[k], exp_seq[k]);
        end
        check("cont_count", conv_count, 4);
        check("cont_overflow", overflow, 0);
        check("cont_timeout", timeout_err, 0);
        repeat (3) @(negedge clk);
        check("cont_stopped", busy, 0);

        // Free-running into a full FIFO: fifth result is dropped
        do_reset();
        exp_seq[0] = 3'b001;
        exp_seq[1] = 3'b011;
        exp_seq[2] = 3'b101;
        exp_seq[3] = 3'b110;
        for (int k = 0; k < 4; k++) begin
            m_codes[next_idx + k] = exp_seq[k];
        end
        m_codes[next_idx + 4] = 3'b010;
        next_idx += 5;
        pulses = 0;
        ov_before = 1'b1;
        #1 continuous = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            if (sar_reset) begin
                pulses++;
                if (pulses == 5) ov_before = overflow;
            end
            if (pulses == 5 && !sar_reset && continuous) continuous = 1'b0;
            if (pulses == 5 && !busy) break;
        end
        check("ovf_pulses", pulses, 5);
        check("ovf_before_5th", ov_before, 0);
        check("ovf_level", fifo_level, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_count", conv_count, 5);
        check("ovf_head", dout, 3'b001);
        drain_fifo();
        check("ovf_drain_n", drained.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < drained.size()) check($sformatf("ovf_drain_%0d", k), drained[k], exp_seq[k]);
        end
        @(posedge clk);
        #1 clear_flags = 1'b1;
        @(posedge clk);
        #1 clear_flags = 1'b0;
        @(negedge clk);
        check("ovf_cleared", overflow, 0);

        // Fill by single shots from the vector table
        do_reset();
        foreach (fill_vec[i]) begin
            run_single(fill_vec[i].code, bc);
            check($sformatf("fill_busy_%0d", i), bc, 3);
            check($sformatf("fill_head_%0d", i), dout, fill_vec[i].exp_head);
            check($sformatf("fill_level_%0d", i), fifo_level, fill_vec[i].exp_level);
            check($sformatf("fill_count_%0d", i), conv_count, fill_vec[i].exp_count);
        end

        // Capture while full with a pop on the same edge
        m_codes[next_idx] = 3'b010;
        next_idx++;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        check("fullpop_busy", busy, 0);
        check("fullpop_level", fifo_level, 4);
        check("fullpop_overflow", overflow, 0);
        check("fullpop_head", dout, 3'b101);
        check("fullpop_count", conv_count, 5);
        exp_seq[0] = 3'b101;
        exp_seq[1] = 3'b110;
        exp_seq[2] = 3'b111;
        exp_seq[3] = 3'b010;
        drain_fifo();
        check("fullpop_drain_n", drained.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < drained.size()) check($sformatf("fullpop_drain_%0d", k), drained[k], exp_seq[k]);
        end

        // Timeout with done held low (stale done during the first WAIT cycle)
        m_hang = 1'b1;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bc = 0;
        tmo_early = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (timeout_err) tmo_early = 1'b1;
            bc++;
        end
        m_hang = 1'b0;
        check("tmo_busy_cycles", bc, 1 + TIMEOUT);
        check("tmo_not_early", tmo_early, 0);
        check("tmo_flag", timeout_err, 1);
        check("tmo_level", fifo_level, 0);
        check("tmo_valid", dout_valid, 0);
        check("tmo_count", conv_count, 5);
        @(posedge clk);
        #1 clear_flags = 1'b1;
        @(posedge clk);
        #1 clear_flags = 1'b0;
        @(negedge clk);
        check("tmo_cleared", timeout_err, 0);

        // Asynchronous reset in the middle of WAIT with two entries buffered
        run_single(3'b011, bc);
        run_single(3'b100, bc);
        check("arst_pre_level", fifo_level, 2);
        m_codes[next_idx] = 3'b001;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_sar_reset", sar_reset, 0);
        check("arst_busy", busy, 0);
        check("arst_dout", dout, 0);
        check("arst_valid", dout_valid, 0);
        check("arst_level", fifo_level, 0);
        check("arst_count", conv_count, 0);
        check("arst_overflow", overflow, 0);
        check("arst_timeout", timeout_err, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("arst_idle", busy, 0);
        run_single(3'b001, bc);
        check("arst_next_busy", bc, 3);
        check("arst_next_dout", dout, 3'b001);
        check("arst_next_count", conv_count, 1);
        check("arst_next_level", fifo_level, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_conv_sequencer.md
Name: sar_conv_sequencer

Overview:
- Host-side sequencer for the 3-bit SAR ADC controller.
- Launches each conversion by pulsing the controller's `reset` input, waits for its `done`, captures the final `sel_wire` code, and buffers results in a small FIFO.
- FIFO output uses a valid/ready handshake.
- Also maintains a conversion counter and sticky timeout/overflow flags, so the controller can run single-shot or free-running without firmware babysitting.

Parameters:
- CODE_W, 3, width of SAR code (sar_sel / dout)
- DEPTH, 4, result FIFO entries (power of 2, >=2)
- MIN_WAIT, 1, WAIT cycles during which sar_done is ignored (masks stale done)
- TIMEOUT, 16, max WAIT cycles before abort (> MIN_WAIT)
- CNT_W, 16, conversion counter width

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request one conversion (sampled in IDLE only)
- continuous  in  1  1 = auto-restart after each conversion
- sar_done  in  1  done from SAR controller
- sar_sel  in  CODE_W  sel_wire from SAR controller
- sar_reset  out  1  drives SAR controller reset (registered)
- busy  out  1  high in START or WAIT
- dout  out  CODE_W  FIFO head code
- dout_valid  out  1  FIFO non-empty
- dout_ready  in  1  consumer accepts dout this cycle
- fifo_level  out  clog2(DEPTH+1)  entries stored
- conv_count  out  CNT_W  successful conversions, wraps
- overflow  out  1  sticky: result dropped, FIFO full
- timeout_err  out  1  sticky: conversion aborted
- clear_flags  in  1  clears overflow and timeout_err

Behaviour:
- Reset (async): state=IDLE, sar_reset=0, busy=0, FIFO empty, dout=0, dout_valid=0, fifo_level=0, conv_count=0, overflow=0, timeout_err=0, wait counter=0.
- FSM states: IDLE, START, WAIT.
- IDLE -> START when start=1 or continuous=1.
- START lasts exactly 1 cycle with sar_reset=1. The controller loads sel=011 on that edge.
- START -> WAIT; wait_cnt cleared to 0.
- WAIT: wait_cnt increments each cycle.
  - sar_done is ignored while wait_cnt < MIN_WAIT.
  - Capture: wait_cnt >= MIN_WAIT and sar_done=1. On that edge, push sar_sel into the FIFO and increment conv_count.
  - After capture: go to START if continuous=1, else IDLE.
  - Timeout: wait_cnt == TIMEOUT-1 without capture. Set timeout_err, no push, no count, go to IDLE.
- Nominal conversion with MIN_WAIT=1: START (1 cycle) + 2 WAIT cycles. sel path is 011 -> 001/101 -> final.
- start asserted during START or WAIT is ignored; no queuing.
- busy = (state != IDLE), decoded from registered state.
- sar_reset is registered and glitch-free; it is 0 in IDLE and WAIT.
- FIFO: push to dout_valid latency is 1 cycle; no bypass.
  - dout = head entry, stable while dout_valid=1 and dout_ready=0.
  - Pop occurs on dout_valid & dout_ready.
  - Push while full and no pop in the same cycle: drop the new code, set overflow. conv_count still increments.
  - Push while full with a pop in the same cycle: both occur, level unchanged, no overflow.
  - Push while empty with dout_ready=1: no pop that cycle.
  - Pointers wrap modulo DEPTH.
- conv_count wraps from 2^CNT_W-1 to 0.
- clear_flags clears both flags next edge. If a set event occurs the same cycle, set wins.
- Async reset mid-WAIT aborts immediately: no push, sar_reset=0.
- continuous deasserted during WAIT: finish the current conversion, then go to IDLE.

Test Plan:
- Reset, then start=1 for 1 cycle, SAR model settles to 110 with add=0. Required: sar_reset high 1 cycle; push 110; dout=110, dout_valid=1 one cycle after capture; conv_count=1; busy high 3 cycles.
- continuous=1, dout_ready=1, codes 000/010/111/100. Required: back-to-back START pulses every 3 cycles; dout sequence 000, 010, 111, 100; conv_count=4; no flags.
- continuous=1, dout_ready=0, 5 conversions. Required: fifo_level=4, overflow=1 after 5th, conv_count=5. Then drain: dout order equals first 4 codes.
- FIFO full with dout_ready=1 on the capture cycle. Required: level stays 4, overflow=0, new code appears last.
- sar_done held 0. Required: timeout_err=1 after TIMEOUT WAIT cycles; state IDLE; no push; conv_count unchanged. Then clear_flags=1 gives timeout_err=0.
- Assert reset mid-WAIT with FIFO holding 2 entries. Required: all outputs at reset values immediately; next start runs normally.
